i3c_target_rx: RTL

Target-side SDR receiver for the I3C bus, sitting at the opposite end of the wire from the bus controller. It oversamples SCL/SDA on the system clock and detects START, repeated START and STOP. It decodes the address header, drives the open-drain ACK on a write to its own or the broadcast address, and then deserialises data bytes. Each data byte is checked against its T-bit (odd parity) before being delivered to the target's application logic.

---
 rtl/i3c_target_rx.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/i3c_target_rx.sv
// I3C SDR target receiver: synchronises SCL/SDA, detects START/Sr/STOP,
// ACKs write headers to its own or the broadcast address, and delivers
// data bytes whose T-bit (odd parity) checks out.
module i3c_target_rx #(
    parameter logic [6:0] TARGET_ADDR = 7'h2A,
    parameter logic [6:0] BCAST_ADDR  = 7'h7E
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       parity_err_o,
    output logic       addr_match_o,
    output logic       start_det_o,
    output logic       stop_det_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACK,
        S_DATA,
        S_TBIT,
        S_IGNORE
    } state_e;

    // Synchroniser stages plus one history register per line.
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;
    logic       scl_s, sda_s;

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       parity_err_q, parity_err_d;
    logic       addr_match_q, addr_match_d;
    logic       start_det_q, start_det_d;
    logic       stop_det_q, stop_det_d;
    logic       sda_oe_q, sda_oe_d;

    logic       start_ev, stop_ev, scl_rise, scl_fall;
    logic [7:0] byte_full;
    logic       hdr_match;

    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];

    // Bus conditions seen on the synchronised lines; START/STOP only while SCL is high.
    assign start_ev  = scl_s &&  sda_prev_q && !sda_s;
    assign stop_ev   = scl_s && !sda_prev_q &&  sda_s;
    assign scl_rise  = scl_s && !scl_prev_q;
    assign scl_fall  = !scl_s && scl_prev_q;

    // Byte as it stands once the bit currently on SDA is shifted in.
    assign byte_full = {shift_q[6:0], sda_s};
    assign hdr_match = !byte_full[0] &&
                       ((byte_full[7:1] == TARGET_ADDR) || (byte_full[7:1] == BCAST_ADDR));

    // Two-flop synchronisers and edge-history registers; reset to the idle-bus level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    // Protocol state, shift register and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'h00;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            addr_match_q <= 1'b0;
            start_det_q  <= 1'b0;
            stop_det_q   <= 1'b0;
            sda_oe_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            addr_match_q <= addr_match_d;
            start_det_q  <= start_det_d;
            stop_det_q   <= stop_det_d;
            sda_oe_q     <= sda_oe_d;
        end
    end

    // Next-state logic: START/STOP override all bit-level activity.
    always_comb begin
        // NOTE: every variable gets a default here, so no path can leave one unassigned and infer a latch.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = 1'b0;
        addr_match_d = addr_match_q;
        start_det_d  = 1'b0;
        stop_det_d   = 1'b0;
        sda_oe_d     = sda_oe_q;

        if (start_ev) begin
            state_d      = S_ADDR;
            bit_cnt_d    = 4'd0;
            shift_d      = 8'h00;
            addr_match_d = 1'b0;
            sda_oe_d     = 1'b0;
            start_det_d  = 1'b1;
        end else if (stop_ev) begin
            state_d      = S_IDLE;
            bit_cnt_d    = 4'd0;
            addr_match_d = 1'b0;
            sda_oe_d     = 1'b0;
            stop_det_d   = 1'b1;
        end else begin
            unique case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_full;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (hdr_match) begin
                                state_d      = S_ACK;
                                addr_match_d = 1'b1;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_ACK: begin
                    // First fall starts driving ACK, second fall (end of 9th bit) releases it.
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (scl_rise) begin
                        shift_d = byte_full;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            state_d   = S_TBIT;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_TBIT: begin
                    // Odd total count of ones across byte and T-bit means the byte is good.
                    if (scl_rise) begin
                        if ((^shift_q) ^ sda_s) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            parity_err_d = 1'b1;
                        end
                        state_d = S_DATA;
                    end
                end
                default: ; // S_IDLE and S_IGNORE only leave on START/STOP
            endcase
        end
    end

    assign sda_o        = 1'b0;
    assign sda_oe_o     = sda_oe_q;
    assign rx_data_o    = rx_data_q;
    assign rx_valid_o   = rx_valid_q;
    assign parity_err_o = parity_err_q;
    assign addr_match_o = addr_match_q;
    assign start_det_o  = start_det_q;
    assign stop_det_o   = stop_det_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule
